// File: rtl/sub_bist_pkg.sv
// Shared types and constants for the sub_bist self-test engine.
// Optional compare-mode sweep is enabled by defining SUB_BIST_CMP_EN.
package sub_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [1:0] MODE_ADD = 2'd0;
  localparam logic [1:0] MODE_SUB = 2'd1;
  localparam logic [1:0] MODE_CMP = 2'd2;

  localparam int ERR_W      = 10;
  localparam int IDX_W      = 10;
  localparam int N_VEC_BASE = 512;
  localparam int N_VEC_CMP  = 768;
`ifdef SUB_BIST_CMP_EN
  localparam int N_VEC = N_VEC_CMP;
`else
  localparam int N_VEC = N_VEC_BASE;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VEC - 1);

  typedef struct packed {
    logic [3:0] out;
    logic       cout;
    logic       ov;
    logic       ov_check;
  } gold_t;

  // Subtract and compare both run the adder in subtract configuration.
  function automatic logic mode_m(input logic [1:0] mode);
    return mode != MODE_ADD;
  endfunction

  function automatic logic mode_c(input logic [1:0] mode);
    return mode == MODE_CMP;
  endfunction

endpackage

// File: rtl/sub_bist_if.sv
// Operand/result bus between the BIST driver (master) and the sub unit (slave).
interface sub_bist_if;
  logic [3:0] A;
  logic [3:0] B;
  logic       M;
  logic       C;
  logic [3:0] OUT;
  logic       cout;
  logic       ov;

  modport master (output A, B, M, C, input OUT, cout, ov);
  modport slave  (input A, B, M, C, output OUT, cout, ov);
endinterface

// File: rtl/sub_golden.sv
// Combinational reference for the 4-bit add/subtract/compare unit.
module sub_golden
  import sub_bist_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       m,
  input  logic       c,
  output gold_t      g
);
  logic [3:0] bx;
  logic [4:0] s5;

  assign bx = m ? ~b : b;
  assign s5 = {1'b0, a} + {1'b0, bx} + {4'b0, m};

  assign g.out      = s5[3:0];
  assign g.cout     = s5[4];
  assign g.ov       = (a[3] == bx[3]) && (s5[3] != a[3]);
  // Compare mode only defines OUT and cout.
  assign g.ov_check = ~c;
endmodule

// File: rtl/sub_bist.sv
// Exhaustive sweep driver/checker for the sub unit with first-failure capture.
// Define SUB_BIST_CMP_EN to add the compare-mode pass (768 vectors instead of 512).
module sub_bist
  import sub_bist_pkg::*;
#(
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  sub_bist_if.master       bus,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [3:0]       fail_a,
  output logic [3:0]       fail_b,
  output logic [1:0]       fail_mode
);
  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [3:0]       wait_cnt;
  logic [3:0]       a_q, b_q;
  logic             m_q, c_q;
  gold_t            g;
  logic             mismatch;

  assign bus.A = a_q;
  assign bus.B = b_q;
  assign bus.M = m_q;
  assign bus.C = c_q;

  sub_golden u_gold (.a(a_q), .b(b_q), .m(m_q), .c(c_q), .g(g));

  assign mismatch = (bus.OUT != g.out) || (bus.cout != g.cout) ||
                    (g.ov_check && (bus.ov != g.ov));
  assign pass     = done && (err_cnt == '0);

`ifdef SUB_BIST_CMP_EN
  always_ff @(posedge clk) begin
    if (rst)                  c_q <= 1'b0;
    else if (state == S_DRIVE) c_q <= mode_c(idx[9:8]);
  end
`else
  assign c_q = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      wait_cnt   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      m_q        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      fail_mode  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_DRIVE;
            idx        <= '0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_mode  <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        S_DRIVE: begin
          a_q      <= idx[7:4];
          b_q      <= idx[3:0];
          m_q      <= mode_m(idx[9:8]);
          wait_cnt <= 4'(SETTLE_CYC - 1);
          state    <= (SETTLE_CYC > 0) ? S_WAIT : S_CHECK;
        end
        S_WAIT: begin
          if (wait_cnt == '0) state <= S_CHECK;
          else                wait_cnt <= wait_cnt - 4'd1;
        end
        S_CHECK: begin
          if (mismatch) begin
            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            // Only the first failing vector is kept for debug.
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_a     <= a_q;
              fail_b     <= b_q;
              fail_mode  <= idx[9:8];
            end
          end
          if (idx == LAST_IDX) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx   <= idx + 1'b1;
            state <= S_DRIVE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sub_bist.sv
// Scoreboard bench for sub_bist: behavioural sub unit with injectable faults,
// expected sweep results queued by the stimulus and checked when done rises.
module tb_sub_bist;
  import sub_bist_pkg::*;

  typedef struct {
    int         cycles;
    int         err;
    logic       pass_e;
    logic       fv;
    logic [3:0] fa;
    logic [3:0] fb;
    logic [1:0] fm;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             busy, done, pass, fail_valid;
  logic [ERR_W-1:0] err_cnt;
  logic [3:0]       fail_a, fail_b;
  logic [1:0]       fail_mode;

  int   fault = 0;
  int   rst_req = 0;
  logic fin_req = 1'b0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  sub_bist_if bus ();

  sub_bist #(.SETTLE_CYC(1)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus.master),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_valid(fail_valid), .fail_a(fail_a), .fail_b(fail_b),
    .fail_mode(fail_mode)
  );

  // Behavioural sub unit: 1 = cout stuck 0, 2 = ov stuck 0, 3 = OUT bit0 flipped for 5-3.
  int ma, mb, msa, msb, mr;
  always_comb begin
    ma  = int'(bus.A);
    mb  = int'(bus.B);
    msa = (ma > 7) ? ma - 16 : ma;
    msb = (mb > 7) ? mb - 16 : mb;
    if (!bus.M) begin
      mr       = ma + mb;
      bus.cout = (mr > 15);
      bus.ov   = (msa + msb > 7) || (msa + msb < -8);
    end else begin
      mr       = ma - mb;
      bus.cout = (ma >= mb);
      bus.ov   = (msa - msb > 7) || (msa - msb < -8);
    end
    bus.OUT = 4'(mr);
    if (fault == 1) bus.cout = 1'b0;
    if (fault == 2) bus.ov = 1'b0;
    if (fault == 3 && ma == 5 && mb == 3 && bus.M) bus.OUT = bus.OUT ^ 4'd1;
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: owns every comparison and the summary.
  initial begin
    int   cyc = 0, t0 = 0, rst_seen = 0;
    logic pbusy = 1'b0, pdone = 1'b0, in_sweep = 1'b0, tmo = 1'b0, c_seen = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_req != rst_seen) begin
        rst_seen = rst_req;
        chk("rst_A", int'(bus.A), 0);
        chk("rst_B", int'(bus.B), 0);
        chk("rst_M", int'(bus.M), 0);
        chk("rst_C", int'(bus.C), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_fail_valid", int'(fail_valid), 0);
        chk("rst_fail_a", int'(fail_a), 0);
        chk("rst_fail_b", int'(fail_b), 0);
        chk("rst_fail_mode", int'(fail_mode), 0);
      end
      if (!rst) begin
        if (busy && !pbusy) begin
          t0 = cyc; in_sweep = 1'b1; tmo = 1'b0; c_seen = 1'b0;
        end
        if (busy && bus.C) c_seen = 1'b1;
        if (in_sweep && busy && !tmo && (cyc - t0 > 2000)) begin
          tmo = 1'b1;
          chk("sweep_timeout", cyc - t0, 1536);
        end
        if (done && !pdone) begin
          in_sweep = 1'b0;
          if (sbq.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            e = sbq.pop_front();
            chk("sweep_cycles", cyc - t0, e.cycles);
            chk("err_cnt", int'(err_cnt), e.err);
            chk("pass", int'(pass), int'(e.pass_e));
            chk("fail_valid", int'(fail_valid), int'(e.fv));
            chk("fail_a", int'(fail_a), int'(e.fa));
            chk("fail_b", int'(fail_b), int'(e.fb));
            chk("fail_mode", int'(fail_mode), int'(e.fm));
            chk("c_never_high", int'(c_seen), 0);
          end
        end
        pbusy = busy;
        pdone = done;
      end else begin
        pbusy = 1'b0; pdone = 1'b0; in_sweep = 1'b0;
      end
      if (fin_req) begin
        chk("scoreboard_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
      end
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic sweep(input int f, input bit repulse, input exp_t e);
    fault = f;
    sbq.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (repulse) begin
      repeat (48) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    exp_t e_pass, e_cout, e_ov, e_one;
    e_pass = '{1536, 0,   1'b1, 1'b0, 4'd0, 4'd0,  2'd0};
    e_cout = '{1536, 256, 1'b0, 1'b1, 4'd1, 4'd15, 2'd0};
    e_ov   = '{1536, 128, 1'b0, 1'b1, 4'd1, 4'd7,  2'd0};
    e_one  = '{1536, 1,   1'b0, 1'b1, 4'd5, 4'd3,  2'd1};

    repeat (3) @(negedge clk);
    rst_req++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    sweep(0, 1'b0, e_pass);
    sweep(1, 1'b0, e_cout);
    sweep(2, 1'b0, e_ov);
    sweep(3, 1'b0, e_one);
    sweep(1, 1'b1, e_cout);

    // Abort a sweep after a failure has been captured; rst must beat start.
    fault = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst_req++;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);

    sweep(0, 1'b0, e_pass);

    repeat (3) @(negedge clk);
    fin_req = 1'b1;
    repeat (5) @(negedge clk);
    $display("FAIL monitor_stalled: got 0 expected 1");
    $fatal(1, "monitor did not finish");
  end
endmodule

// File: doc/sub_bist.md
# sub_bist

Self-checking, synthesizable stimulus driver and checker for the 4-bit add/subtract/compare unit `sub`. It sits on the driving side of that unit's operand interface and sweeps every (A, B) pair through each supported mode. After `SETTLE_CYC` cycles it samples `OUT`/`cout`/`ov` and compares them against an internal golden model. It reports an error count and the first failing vector, and replaces bench-only stimulus with a silicon/FPGA-usable self-test.

## Interface
- `SETTLE_CYC`, default 1: idle cycles between driving operands and sampling results; range 0–15.
- `clk`  in  1  sole clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a sweep; honored only in IDLE or DONE.
- `A`, `B`  out  4 each  operands to `sub`, registered.
- `M`  out  1  mode to `sub`: 0 = add, 1 = subtract, registered.
- `C`  out  1  compare select to `sub`, registered.
- `OUT`  in  4  result from `sub`.
- `cout`  in  1  carry from `sub`.
- `ov`  in  1  signed overflow from `sub`.
- `busy`  out  1  sweep in progress.
- `done`  out  1  sweep finished; held until next `start` or `rst`.
- `pass`  out  1  `done && err_cnt == 0`.
- `err_cnt`  out  10  count of mismatching vectors.
- `fail_valid`  out  1  a first failure has been captured.
- `fail_a`, `fail_b`  out  4 each  operands of the first failing vector.
- `fail_mode`  out  2  mode of the first failing vector.

## Operation
- Vector index is `{mode[1:0], A[3:0], B[3:0]}`, incremented with B fastest; mode 0 = add (M=0, C=0), 1 = sub (M=1, C=0), 2 = cmp (M=1, C=1, macro only).
- FSM states:
  - IDLE: `start` → DRIVE, clearing the index, `err_cnt`, and the fail capture.
  - DRIVE: operand registers load the current vector. → WAIT if `SETTLE_CYC > 0`, else → CHECK.
  - WAIT: counts `SETTLE_CYC` cycles, then → CHECK.
  - CHECK: compares and updates counters. Last vector → DONE, otherwise increment the index → DRIVE.
  - DONE: `start` → DRIVE, same clears as from IDLE.
- Golden model, with `Bx = M ? ~B : B`:
  - `s5 = A + Bx + M` (5-bit).
  - Expected `OUT = s5[3:0]`, `cout = s5[4]`.
  - Expected `ov = (A[3] == Bx[3]) && (s5[3] != A[3])`.
  - Cmp mode checks `OUT` and `cout` (which equals A ≥ B unsigned) only; `ov` is ignored.
- A mismatch in any checked field increments `err_cnt`, which saturates at 1023.
- The first mismatch latches `fail_a`/`fail_b`/`fail_mode` and sets `fail_valid`. Later mismatches do not overwrite the capture.
- `start` in DRIVE/WAIT/CHECK is ignored.

## Timing
- Reset values: `A = B = 0`, `M = C = 0`, `busy = done = pass = 0`, `err_cnt = 0`, `fail_valid = 0`, `fail_a = fail_b = 0`, `fail_mode = 0`; state IDLE.
- `busy` rises the cycle after `start` is accepted. It falls in the same cycle `done` rises, which is the cycle after the last CHECK.
- Each vector takes `2 + SETTLE_CYC` cycles; a sweep takes `N × (2 + SETTLE_CYC)` cycles, with N = 512 (768 with macro).
- `rst` mid-sweep returns all outputs to their reset values on the next edge. No partial results survive.
- `rst` and `start` asserted together: `rst` wins.

## Configuration
- `SUB_BIST_CMP_EN`:
  - Defined: mode 2 (compare) is swept; N = 768.
  - Undefined: mode-2 logic is absent, `C` is tied 0, and the index wraps from mode 1 to DONE; N = 512.

## Structure
- `sub_bist_pkg`:
  - FSM state enum.
  - Mode encodings `MODE_ADD = 0`, `MODE_SUB = 1`, `MODE_CMP = 2`.
  - Vector-count constants.
  - `err_cnt` width constant (10).
- One sub-module, `sub_golden`: a combinational golden model taking A, B, M, C and producing expected `OUT`/`cout`/`ov` plus the `ov_check` enable.

## Test plan
- Correct `sub` attached, `SETTLE_CYC = 1`, macro off, `start` pulsed → `done` exactly 1536 cycles later; `pass = 1`, `err_cnt = 0`, `fail_valid = 0`.
- `cout` forced to 0, macro off → `err_cnt = 256` (120 add carries + 136 sub A ≥ B cases); `fail_a = 1`, `fail_b = 15`, `fail_mode = 0`, `pass = 0`.
- Macro on, correct `sub`, `SETTLE_CYC = 0` → `done` after 1536 cycles; `C` observed high only during the final 256 vectors; `pass = 1`.
- `rst` asserted 100 cycles into a sweep → all outputs at reset values the next cycle. A fresh `start` then yields a full-length sweep with correct counts.
- `start` re-pulsed at cycle 50 while `busy` → ignored; sweep length and `err_cnt` unchanged. `start` in DONE → counters clear and a new sweep begins.
